mult_ctrl: RTL and testbench

- Sequencer placed directly upstream of the `mult` multiplier core; it also captures that core's result.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time to the multiplier, holding operands stable. The multiplier may be the combinational core or the iterative shift-add core; `mul_ready` semantics cover both.
- Returns the 2*SZ-bit product on a valid/ready result stream toward the AXI4/Avalon slave wrappers.

---
 rtl/mult_ctrl.sv | 141 ++++++++++++++
 tb/tb_mult_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Operand FIFO and one-at-a-time sequencer in front of the mult core; captures its product.
// Optional op_count handshake counter is enabled by defining MULT_CTRL_PERF_EN.
module mult_ctrl #(
    parameter int unsigned SZ      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_LAT = 1
) (
    input  logic            clk,
    input  logic            _rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SZ-1:0]   in_a,
    input  logic [SZ-1:0]   in_b,
    output logic [SZ-1:0]   mul_a,
    output logic [SZ-1:0]   mul_b,
    output logic            mul_start,
    input  logic [2*SZ-1:0] mul_res,
    input  logic            mul_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*SZ-1:0] out_res,
    output logic            busy
`ifdef MULT_CTRL_PERF_EN
    ,
    output logic [31:0]     op_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MIN_LAT + 1);
    localparam logic [AW:0]   PtrOne  = 1;
    localparam logic [CW-1:0] CntOne  = 1;
    localparam logic [CW-1:0] CntLoad = CW'(MIN_LAT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [SZ-1:0]     fifo_a [DEPTH];
    logic [SZ-1:0]     fifo_b [DEPTH];
    logic [SZ-1:0]     mul_a_q, mul_b_q;
    logic [2*SZ-1:0]   out_res_q;
    logic              full, empty, push, pop, capture;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = in_valid && !full;

    assign in_ready  = !full;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_res   = out_res_q;
    assign mul_start = (state_q == StStart);
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle) || !empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                // mul_ready is only trusted once the minimum latency has elapsed.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else if (mul_ready) begin
                    capture = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr_q[AW-1:0]] <= in_a;
            fifo_b[wr_ptr_q[AW-1:0]] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            out_res_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                mul_a_q  <= fifo_a[rd_ptr_q[AW-1:0]];
                mul_b_q  <= fifo_b[rd_ptr_q[AW-1:0]];
            end
            if (capture) begin
                out_res_q <= mul_res;
            end
        end
    end

`ifdef MULT_CTRL_PERF_EN
    logic [31:0] op_count_q;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            op_count_q <= '0;
        end else if (out_valid && out_ready) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: a fast instance (MIN_LAT=1, combinational multiplier)
// and a slow instance (MIN_LAT=2, delayed mul_ready with bogus early products).
module tb_mult_ctrl;

    localparam int unsigned SZ = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          f_in_valid, f_in_ready, f_mul_start, f_mul_ready;
    logic          f_out_valid, f_out_ready, f_busy;
    logic [31:0]   f_in_a, f_in_b, f_mul_a, f_mul_b;
    logic [63:0]   f_mul_res, f_out_res;

    logic          s_in_valid, s_in_ready, s_mul_start, s_mul_ready;
    logic          s_out_valid, s_out_ready, s_busy;
    logic [31:0]   s_in_a, s_in_b, s_mul_a, s_mul_b;
    logic [63:0]   s_mul_res, s_out_res;
    logic [3:0]    s_cnt;

`ifdef MULT_CTRL_PERF_EN
    logic [31:0]   f_op_count, s_op_count;
`endif

    assign f_mul_res   = 64'(f_mul_a) * 64'(f_mul_b);
    assign f_mul_ready = 1'b1;

    // Slow core: spurious ready one cycle after start, real product from 5 cycles after start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_cnt <= 4'd0;
        end else if (s_mul_start) begin
            s_cnt <= 4'd1;
        end else if (s_cnt != 4'd0 && s_cnt < 4'd7) begin
            s_cnt <= s_cnt + 4'd1;
        end
    end
    assign s_mul_ready = (s_cnt == 4'd1) || (s_cnt >= 4'd5);
    assign s_mul_res   = (s_cnt >= 4'd5) ? 64'(s_mul_a) * 64'(s_mul_b) : 64'hBAD0_BAD0_BAD0_BAD0;

    mult_ctrl #(.SZ(SZ), .DEPTH(4), .MIN_LAT(1)) u_fast (
        .clk       (clk),
        ._rst      (rst_n),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .in_a      (f_in_a),
        .in_b      (f_in_b),
        .mul_a     (f_mul_a),
        .mul_b     (f_mul_b),
        .mul_start (f_mul_start),
        .mul_res   (f_mul_res),
        .mul_ready (f_mul_ready),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .out_res   (f_out_res),
        .busy      (f_busy)
`ifdef MULT_CTRL_PERF_EN
        ,
        .op_count  (f_op_count)
`endif
    );

    mult_ctrl #(.SZ(SZ), .DEPTH(4), .MIN_LAT(2)) u_slow (
        .clk       (clk),
        ._rst      (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .mul_a     (s_mul_a),
        .mul_b     (s_mul_b),
        .mul_start (s_mul_start),
        .mul_res   (s_mul_res),
        .mul_ready (s_mul_ready),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_res   (s_out_res),
        .busy      (s_busy)
`ifdef MULT_CTRL_PERF_EN
        ,
        .op_count  (s_op_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one pair into the idle fast instance and wait for its result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        bit got;
        got         = 1'b0;
        f_out_ready = 1'b1;
        f_in_valid  = 1'b1;
        f_in_a      = a;
        f_in_b      = b;
        step();
        f_in_valid  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (f_out_valid) begin
                got = 1'b1;
                chk(tag, f_out_res, exp);
            end
            step();
        end
        chkb({tag, "_seen"}, got, 1'b1);
    endtask

    logic [31:0] pa [6] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    logic [31:0] pb [6] = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
    logic [63:0] res [6];
    logic [63:0] r;
    int          idx, nres, acc_res, seen_valid, seen_start;
    bit          acc, hs, got;

    initial begin
        rst_n       = 1'b0;
        f_in_valid  = 1'b0;
        f_in_a      = '0;
        f_in_b      = '0;
        f_out_ready = 1'b0;
        s_in_valid  = 1'b0;
        s_in_a      = '0;
        s_in_b      = '0;
        s_out_ready = 1'b0;
        step();
        step();

        chkb("rst_in_ready", f_in_ready, 1'b1);
        chkb("rst_out_valid", f_out_valid, 1'b0);
        chkb("rst_busy", f_busy, 1'b0);
        chkb("rst_mul_start", f_mul_start, 1'b0);
        chk("rst_mul_a", 64'(f_mul_a), 64'd0);
        chk("rst_out_res", f_out_res, 64'd0);
        chkb("rst_slow_in_ready", s_in_ready, 1'b1);

        // Single op latency: push in cycle 0, result visible in cycle 4.
        rst_n       = 1'b1;
        f_out_ready = 1'b1;
        f_in_valid  = 1'b1;
        f_in_a      = 32'd3;
        f_in_b      = 32'd5;
        step();
        f_in_valid = 1'b0;
        chkb("c1_busy", f_busy, 1'b1);
        chkb("c1_mul_start", f_mul_start, 1'b0);
        chkb("c1_out_valid", f_out_valid, 1'b0);
        step();
        chkb("c2_mul_start", f_mul_start, 1'b1);
        chk("c2_mul_a", 64'(f_mul_a), 64'd3);
        step();
        chkb("c3_mul_start", f_mul_start, 1'b0);
        chkb("c3_out_valid", f_out_valid, 1'b0);
        step();
        chkb("c4_out_valid", f_out_valid, 1'b1);
        chk("c4_out_res", f_out_res, 64'd15);
        chkb("c4_mul_start", f_mul_start, 1'b0);
        step();
        chkb("c5_out_valid", f_out_valid, 1'b0);

        run_op("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("zero_x_max", 32'h0, 32'hFFFF_FFFF, 64'h0);

        // FIFO full: one op parked in HOLD plus four queued.
        f_out_ready = 1'b0;
        idx         = 0;
        for (int c = 0; c < 12; c++) begin
            f_in_valid = 1'b1;
            f_in_a     = pa[idx];
            f_in_b     = pb[idx];
            acc        = f_in_ready;
            step();
            if (acc) idx++;
        end
        chk("full_accepted", 64'(idx), 64'd5);
        chkb("full_in_ready", f_in_ready, 1'b0);
        chkb("full_out_valid", f_out_valid, 1'b1);

        f_out_ready = 1'b1;
        nres        = 0;
        acc_res     = -1;
        for (int c = 0; c < 80 && nres < 6; c++) begin
            hs  = f_out_valid;
            r   = f_out_res;
            acc = f_in_valid && f_in_ready;
            step();
            if (acc) begin
                acc_res    = nres;
                idx++;
                f_in_valid = 1'b0;
            end
            if (hs) begin
                res[nres] = r;
                nres++;
            end
        end
        chk("drain_count", 64'(nres), 64'd6);
        chk("sixth_accepted", 64'(idx), 64'd6);
        chkb("sixth_after_drain", acc_res >= 1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("order_%0d", i), res[i], 64'(pa[i]) * 64'(pb[i]));
        end

        // Backpressure in HOLD with another op queued behind it.
        f_out_ready = 1'b0;
        f_in_valid  = 1'b1;
        f_in_a      = 32'd11;
        f_in_b      = 32'd13;
        step();
        f_in_a      = 32'd2;
        f_in_b      = 32'd2;
        step();
        f_in_valid  = 1'b0;
        got         = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (f_out_valid) got = 1'b1;
            else step();
        end
        chkb("bp_hold_reached", got, 1'b1);
        for (int c = 0; c < 10; c++) begin
            chkb("bp_out_valid", f_out_valid, 1'b1);
            chk("bp_out_res", f_out_res, 64'd143);
            chk("bp_mul_a", 64'(f_mul_a), 64'd11);
            chk("bp_mul_b", 64'(f_mul_b), 64'd13);
            chkb("bp_mul_start", f_mul_start, 1'b0);
            step();
        end
        f_out_ready = 1'b1;
        nres        = 0;
        for (int c = 0; c < 30 && nres < 2; c++) begin
            hs = f_out_valid;
            r  = f_out_res;
            step();
            if (hs) begin
                res[nres] = r;
                nres++;
            end
        end
        chk("bp_drain_count", 64'(nres), 64'd2);
        chk("bp_first", res[0], 64'd143);
        chk("bp_second", res[1], 64'd4);
`ifdef MULT_CTRL_PERF_EN
        chk("fast_op_count", 64'(f_op_count), 64'd11);
`endif

        // Slow core: start in cycle 2, real ready in cycle 7, result in cycle 8.
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_a      = 32'd7;
        s_in_b      = 32'd9;
        step();
        s_in_valid = 1'b0;
        step();
        chkb("slow_start", s_mul_start, 1'b1);
        for (int c = 0; c < 5; c++) step();
        chkb("slow_c7_out_valid", s_out_valid, 1'b0);
        step();
        chkb("slow_c8_out_valid", s_out_valid, 1'b1);
        chk("slow_out_res", s_out_res, 64'd63);
        step();

        // Reset during WAIT with two pairs still queued.
        s_in_valid = 1'b1;
        s_in_a     = 32'd4;
        s_in_b     = 32'd4;
        step();
        s_in_a     = 32'd5;
        s_in_b     = 32'd5;
        step();
        s_in_a     = 32'd6;
        s_in_b     = 32'd6;
        step();
        s_in_valid = 1'b0;
        chkb("midop_busy", s_busy, 1'b1);
        chkb("midop_in_wait", s_mul_start || s_out_valid, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chkb("post_rst_out_valid", s_out_valid, 1'b0);
        chkb("post_rst_busy", s_busy, 1'b0);
        chkb("post_rst_in_ready", s_in_ready, 1'b1);
        chk("post_rst_mul_a", 64'(s_mul_a), 64'd0);
        chk("post_rst_out_res", s_out_res, 64'd0);
`ifdef MULT_CTRL_PERF_EN
        chk("post_rst_op_count", 64'(s_op_count), 64'd0);
`endif
        seen_valid = 0;
        seen_start = 0;
        for (int c = 0; c < 20; c++) begin
            if (s_out_valid) seen_valid++;
            if (s_mul_start) seen_start++;
            step();
        end
        chk("post_rst_no_result", 64'(seen_valid), 64'd0);
        chk("post_rst_no_start", 64'(seen_start), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
